// File: rtl/mpe_pkg.sv
// Shared definitions for the matrix processing element.
//   LANES/DATA_W : beat geometry (32 signed 16-bit lanes per 512-bit beat)
//   PROD_W       : width of one lane product
//   SUM_W        : width of the 32-lane adder-tree sum
//   ACC_W        : accumulator width (covers up to 255 beats per micro-op)
//   UOP_W        : micro-op width (unsigned beat count)
package mpe_pkg;

    localparam int unsigned LANES  = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = 37;
    localparam int unsigned ACC_W  = 45;
    localparam int unsigned UOP_W  = 8;
    localparam int unsigned BEAT_W = LANES * DATA_W;
    localparam int unsigned RES_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mpe_dot32.sv
// 32-lane signed dot product, two-stage pipeline.
//   clk, rst    : clock, synchronous active-high reset (clears valids only)
//   in_valid    : a beat is presented on neuron/weight this cycle
//   neuron      : 32 signed 16-bit lanes, lane i = bits[16i+15:16i]
//   weight      : same layout as neuron
//   prod_valid  : stage 1 (registered products) holds a beat
//   sum_valid   : stage 2 (registered tree sum) holds a beat
//   sum         : signed 37-bit sum of the 32 lane products
module mpe_dot32
    import mpe_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [BEAT_W-1:0]       neuron,
    input  logic [BEAT_W-1:0]       weight,
    output logic                    prod_valid,
    output logic                    sum_valid,
    output logic signed [SUM_W-1:0] sum
);

    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic signed [SUM_W-1:0]  tree_d;

    always_comb begin
        prod_d = '{default: '0};
        for (int unsigned i = 0; i < LANES; i++) begin
            prod_d[i] = PROD_W'(signed'(neuron[i*DATA_W +: DATA_W]))
                      * PROD_W'(signed'(weight[i*DATA_W +: DATA_W]));
        end
    end

    // Products are sign-extended before summing so the tree never overflows.
    always_comb begin
        tree_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            tree_d = tree_d + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_valid <= 1'b0;
            sum_valid  <= 1'b0;
        end else begin
            prod_valid <= in_valid;
            sum_valid  <= prod_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            prod_q <= prod_d;
        end
        if (prod_valid) begin
            sum <= tree_d;
        end
    end

endmodule

// File: rtl/matrix_pe_core.sv
// Matrix processing element: per micro-op, accumulates the dot products of
// N paired neuron/weight beats and emits the low 32 bits of the sum.
//   clk, rst                      : clock, synchronous active-high reset
//   nram_mpe_neuron[_valid/_ready]: neuron beat channel
//   wram_mpe_weight[_valid/_ready]: weight beat channel
//   ib_ctl_uop[_valid/_ready]     : micro-op channel, unsigned beat count N
//   result                        : acc[31:0] of the last finished micro-op
//   vld_o                         : one-cycle pulse, result updated
module matrix_pe_core
    import mpe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] nram_mpe_neuron,
    input  logic              nram_mpe_neuron_valid,
    output logic              nram_mpe_neuron_ready,
    input  logic [BEAT_W-1:0] wram_mpe_weight,
    input  logic              wram_mpe_weight_valid,
    output logic              wram_mpe_weight_ready,
    input  logic [UOP_W-1:0]  ib_ctl_uop,
    input  logic              ib_ctl_uop_valid,
    output logic              ib_ctl_uop_ready,
    output logic [RES_W-1:0]  result,
    output logic              vld_o
);

    state_t state, state_next;

    logic [UOP_W-1:0]        n_q;
    logic [UOP_W-1:0]        beat_cnt;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_next;
    logic                    uop_fire;
    logic                    beat_fire;
    logic                    last_beat;
    logic                    finish;
    logic                    prod_valid;
    logic                    sum_valid;
    logic signed [SUM_W-1:0] sum;

    // Beat transfer needs both channels valid; neither side is consumed alone.
    assign beat_fire = (state == RUN) && !rst
                     && nram_mpe_neuron_valid && wram_mpe_weight_valid;
    assign uop_fire  = ib_ctl_uop_valid && ib_ctl_uop_ready;
    assign last_beat = beat_fire && ((beat_cnt + UOP_W'(1)) == n_q);
    // In DRAIN every beat has been issued; once stage 1 is empty the only
    // possible in-flight beat is in stage 2 and lands in acc_next this cycle.
    assign finish    = (state == DRAIN) && !prod_valid;

    assign acc_next = sum_valid
                    ? acc + {{(ACC_W-SUM_W){sum[SUM_W-1]}}, sum}
                    : acc;

    mpe_dot32 u_dot32 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (beat_fire),
        .neuron     (nram_mpe_neuron),
        .weight     (wram_mpe_weight),
        .prod_valid (prod_valid),
        .sum_valid  (sum_valid),
        .sum        (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next            = state;
        ib_ctl_uop_ready      = 1'b0;
        nram_mpe_neuron_ready = 1'b0;
        wram_mpe_weight_ready = 1'b0;
        case (state)
            IDLE: begin
                ib_ctl_uop_ready = !rst;
                if (uop_fire) begin
                    state_next = (ib_ctl_uop == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                // Each ready follows only the opposite channel's valid.
                nram_mpe_neuron_ready = wram_mpe_weight_valid && !rst;
                wram_mpe_weight_ready = nram_mpe_neuron_valid && !rst;
                if (last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= '0;
            beat_cnt <= '0;
            acc      <= '0;
            result   <= '0;
            vld_o    <= 1'b0;
        end else begin
            vld_o <= 1'b0;
            if (uop_fire) begin
                n_q      <= ib_ctl_uop;
                beat_cnt <= '0;
                acc      <= '0;
            end else begin
                acc <= acc_next;
                if (beat_fire) begin
                    beat_cnt <= beat_cnt + UOP_W'(1);
                end
            end
            if (finish) begin
                vld_o  <= 1'b1;
                result <= acc_next[RES_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_matrix_pe_core.sv
// Self-checking bench for matrix_pe_core: directed vector table, reset and
// N=0 corner sequences, and a randomized multi-uop run against a plain
// arithmetic dot-product model.
module tb_matrix_pe_core;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] nram_mpe_neuron;
    logic         nram_mpe_neuron_valid;
    logic         nram_mpe_neuron_ready;
    logic [511:0] wram_mpe_weight;
    logic         wram_mpe_weight_valid;
    logic         wram_mpe_weight_ready;
    logic [7:0]   ib_ctl_uop;
    logic         ib_ctl_uop_valid;
    logic         ib_ctl_uop_ready;
    logic [31:0]  result;
    logic         vld_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int single_err = 0;
    logic [31:0] got_q[$];

    matrix_pe_core dut (
        .clk                   (clk),
        .rst                   (rst),
        .nram_mpe_neuron       (nram_mpe_neuron),
        .nram_mpe_neuron_valid (nram_mpe_neuron_valid),
        .nram_mpe_neuron_ready (nram_mpe_neuron_ready),
        .wram_mpe_weight       (wram_mpe_weight),
        .wram_mpe_weight_valid (wram_mpe_weight_valid),
        .wram_mpe_weight_ready (wram_mpe_weight_ready),
        .ib_ctl_uop            (ib_ctl_uop),
        .ib_ctl_uop_valid      (ib_ctl_uop_valid),
        .ib_ctl_uop_ready      (ib_ctl_uop_ready),
        .result                (result),
        .vld_o                 (vld_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Protocol monitor: both data channels transfer together or not at all,
    // and a result pulse always coincides with uop readiness.
    always @(negedge clk) begin
        if (!rst) begin
            if ((nram_mpe_neuron_valid && nram_mpe_neuron_ready) !=
                (wram_mpe_weight_valid && wram_mpe_weight_ready))
                single_err++;
            if (vld_o) begin
                vld_cnt++;
                got_q.push_back(result);
                chk("uop_ready_with_vld", ib_ctl_uop_ready, 1);
            end
        end
    end

    function automatic logic [511:0] fill(input logic [15:0] v);
        logic [511:0] r;
        for (int i = 0; i < 32; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    function automatic longint dot(input logic [511:0] a, input logic [511:0] b);
        longint s = 0;
        for (int i = 0; i < 32; i++)
            s += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
        return s;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        string       name;
        logic [15:0] nv;
        logic [15:0] wv;
        int          n;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    // Send one uop with constant-lane beats; data valids stay high throughout.
    task automatic run_dir(input vec_t v);
        int hs, ref_c, t, done;
        bit seen, any_rdy;
        @(posedge clk); #1;
        ib_ctl_uop = 8'(v.n);
        ib_ctl_uop_valid = 1'b1;
        nram_mpe_neuron = fill(v.nv);
        wram_mpe_weight = fill(v.wv);
        @(negedge clk);
        chk({v.name, "_uop_ready"}, ib_ctl_uop_ready, 1);
        hs = cyc;
        ref_c = hs;
        @(posedge clk); #1;
        ib_ctl_uop_valid = 1'b0;
        nram_mpe_neuron_valid = 1'b1;
        wram_mpe_weight_valid = 1'b1;
        done = 0;
        t = 0;
        while (done < v.n && t < 50) begin
            @(negedge clk);
            if (nram_mpe_neuron_ready && wram_mpe_weight_ready) begin
                done++;
                ref_c = cyc;
            end
            t++;
            @(posedge clk); #1;
        end
        chk({v.name, "_beats"}, done, v.n);
        if (v.n > 0) begin
            nram_mpe_neuron_valid = 1'b0;
            wram_mpe_weight_valid = 1'b0;
        end
        seen = 0;
        any_rdy = 0;
        t = 0;
        while (!seen && t < 20) begin
            @(negedge clk);
            if (nram_mpe_neuron_ready || wram_mpe_weight_ready) any_rdy = 1;
            if (vld_o) begin
                seen = 1;
                chk({v.name, "_latency"}, cyc - ref_c, v.lat);
                chk({v.name, "_result"}, result, v.exp);
            end
            t++;
        end
        chk({v.name, "_vld_seen"}, seen, 1);
        chk({v.name, "_no_data_ready"}, any_rdy, 0);
        nram_mpe_neuron_valid = 1'b0;
        wram_mpe_weight_valid = 1'b0;
        @(negedge clk);
        chk({v.name, "_pulse_one_cycle"}, vld_o, 0);
        chk({v.name, "_result_held"}, result, v.exp);
    endtask

    vec_t vecs[5];
    int   uop_n[4];
    logic [511:0] nb[140];
    logic [511:0] wb[140];
    logic [31:0]  exp_q[$];

    initial begin
        int base, t, cnt, idx;
        bit to_flag;
        longint acc;

        vecs[0] = '{"ones",   16'h0001, 16'h0001, 1, 32'h0000_0020, 3};
        vecs[1] = '{"neg",    16'hFFFF, 16'h0002, 2, 32'hFFFF_FF80, 3};
        vecs[2] = '{"trunc",  16'h7FFF, 16'h7FFF, 4, 32'hFF80_0080, 3};
        vecs[3] = '{"minmax", 16'h8000, 16'h7FFF, 3, 32'h0030_0000, 3};
        vecs[4] = '{"n0",     16'h1234, 16'h5678, 0, 32'h0000_0000, 2};

        rst = 1'b1;
        nram_mpe_neuron = '0;
        wram_mpe_weight = '0;
        nram_mpe_neuron_valid = 1'b0;
        wram_mpe_weight_valid = 1'b0;
        ib_ctl_uop = '0;
        ib_ctl_uop_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_uop_ready", ib_ctl_uop_ready, 0);
        chk("rst_nram_ready", nram_mpe_neuron_ready, 0);
        chk("rst_wram_ready", wram_mpe_weight_ready, 0);
        chk("rst_vld", vld_o, 0);
        chk("rst_result", result, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_uop_ready", ib_ctl_uop_ready, 1);

        // Directed vector table
        for (int i = 0; i < 5; i++) run_dir(vecs[i]);

        // Reset in RUN after 3 of 5 beats
        @(posedge clk); #1;
        ib_ctl_uop = 8'd5;
        ib_ctl_uop_valid = 1'b1;
        nram_mpe_neuron = fill(16'h0100);
        wram_mpe_weight = fill(16'h0100);
        @(negedge clk);
        @(posedge clk); #1;
        ib_ctl_uop_valid = 1'b0;
        nram_mpe_neuron_valid = 1'b1;
        wram_mpe_weight_valid = 1'b1;
        cnt = 0;
        t = 0;
        while (cnt < 3 && t < 20) begin
            @(negedge clk);
            if (nram_mpe_neuron_ready && wram_mpe_weight_ready) cnt++;
            t++;
            @(posedge clk); #1;
        end
        chk("abort_beats_before_rst", cnt, 3);
        rst = 1'b1;
        base = vld_cnt;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_nram_ready", nram_mpe_neuron_ready, 0);
        chk("abort_wram_ready", wram_mpe_weight_ready, 0);
        chk("abort_uop_ready", ib_ctl_uop_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_after_rst", ib_ctl_uop_ready, 1);
        chk("abort_data_ready_after_rst", nram_mpe_neuron_ready | wram_mpe_weight_ready, 0);
        repeat (10) @(negedge clk);
        chk("abort_no_vld", vld_cnt - base, 0);
        nram_mpe_neuron_valid = 1'b0;
        wram_mpe_weight_valid = 1'b0;
        run_dir('{"after_abort", 16'h0003, 16'h0005, 1, 32'h0000_01E0, 3});

        // Randomized run: four uops totalling 140 beats
        uop_n = '{60, 1, 37, 42};
        idx = 0;
        exp_q.delete();
        for (int u = 0; u < 4; u++) begin
            acc = 0;
            for (int b = 0; b < uop_n[u]; b++) begin
                nb[idx] = rand512();
                wb[idx] = rand512();
                acc += dot(nb[idx], wb[idx]);
                idx++;
            end
            exp_q.push_back(acc[31:0]);
        end
        got_q.delete();
        base = vld_cnt;
        single_err = 0;
        to_flag = 0;
        fork
            begin : uop_drv
                for (int u = 0; u < 4; u++) begin
                    int tu;
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    @(posedge clk); #1;
                    ib_ctl_uop = 8'(uop_n[u]);
                    ib_ctl_uop_valid = 1'b1;
                    tu = 0;
                    while (1) begin
                        @(negedge clk);
                        if (ib_ctl_uop_ready) break;
                        if (++tu > 4000) begin to_flag = 1; break; end
                        @(posedge clk); #1;
                    end
                    @(posedge clk); #1;
                    ib_ctl_uop_valid = 1'b0;
                end
            end
            begin : data_drv
                for (int b = 0; b < 140; b++) begin
                    int td;
                    td = 0;
                    while (1) begin
                        @(posedge clk); #1;
                        nram_mpe_neuron = nb[b];
                        wram_mpe_weight = wb[b];
                        nram_mpe_neuron_valid = ($urandom_range(0, 99) < 70);
                        wram_mpe_weight_valid = ($urandom_range(0, 99) < 70);
                        @(negedge clk);
                        if (nram_mpe_neuron_valid && nram_mpe_neuron_ready &&
                            wram_mpe_weight_valid && wram_mpe_weight_ready) break;
                        if (++td > 4000) begin to_flag = 1; break; end
                    end
                end
                @(posedge clk); #1;
                nram_mpe_neuron_valid = 1'b0;
                wram_mpe_weight_valid = 1'b0;
            end
            begin : collect
                int tc;
                tc = 0;
                while (vld_cnt < base + 4 && tc < 10000) begin
                    @(negedge clk);
                    tc++;
                end
            end
        join
        repeat (10) @(negedge clk);
        chk("rand_no_timeout", to_flag, 0);
        chk("rand_pulse_count", vld_cnt - base, 4);
        chk("rand_no_single_beat", single_err, 0);
        for (int k = 0; k < 4; k++) begin
            if (k < got_q.size())
                chk($sformatf("rand_result_%0d", k), got_q[k], exp_q[k]);
            else
                chk($sformatf("rand_result_%0d_missing", k), 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
